// File: rtl/snake_pkg.sv
// Shared snake-grid definitions: direction codes, cell packing and wrap-around stepping.
// Latency: none (package of constants, types and pure functions).
// Backpressure: not applicable.
// Cells are packed {y[2:0], x[2:0]} on an 8x8 torus; step_cell is shared with the head stepper.
package snake_pkg;

  localparam int GRID_BITS = 3;
  localparam int CELL_BITS = 2 * GRID_BITS;

  localparam logic [1:0] DIR_XP = 2'b00;
  localparam logic [1:0] DIR_YP = 2'b01;
  localparam logic [1:0] DIR_XN = 2'b10;
  localparam logic [1:0] DIR_YN = 2'b11;

  typedef struct packed {
    logic [GRID_BITS-1:0] y;
    logic [GRID_BITS-1:0] x;
  } cell_t;

  function automatic logic [CELL_BITS-1:0] pack_cell(input logic [GRID_BITS-1:0] y,
                                                      input logic [GRID_BITS-1:0] x);
    return {y, x};
  endfunction

  function automatic cell_t unpack_cell(input logic [CELL_BITS-1:0] idx);
    return cell_t'(idx);
  endfunction

  // Per-axis 3-bit arithmetic gives the toroidal wrap for free (7+1=0, 0-1=7).
  function automatic logic [CELL_BITS-1:0] step_cell(input logic [CELL_BITS-1:0] idx,
                                                      input logic [1:0]           dir);
    cell_t c;
    c = unpack_cell(idx);
    case (dir)
      DIR_XP:  c.x = c.x + GRID_BITS'(1);
      DIR_YP:  c.y = c.y + GRID_BITS'(1);
      DIR_XN:  c.x = c.x - GRID_BITS'(1);
      default: c.y = c.y - GRID_BITS'(1);
    endcase
    return pack_cell(c.y, c.x);
  endfunction

endpackage

// File: rtl/snake_tail_tracker_if.sv
// Move-strobe inputs and tail-status outputs of the snake tail tracker.
// Latency: none (signal bundle only).
// Backpressure: none; step is a fire-and-forget strobe.
// master: drives clear/step/next_dir/grow, observes idx_tail/vacate_valid/idx_vacated/length/full.
// slave : the tracker itself.
interface snake_tail_tracker_if;
  logic       clear;
  logic       step;
  logic [1:0] next_dir;
  logic       grow;
  logic [5:0] idx_tail;
  logic       vacate_valid;
  logic [5:0] idx_vacated;
  logic [6:0] length;
  logic       full;

  modport master (
    output clear, step, next_dir, grow,
    input  idx_tail, vacate_valid, idx_vacated, length, full
  );

  modport slave (
    input  clear, step, next_dir, grow,
    output idx_tail, vacate_valid, idx_vacated, length, full
  );
endinterface

// File: rtl/snake_dir_fifo.sv
// Ring buffer of 2-bit move directions, DEPTH entries, pointers wrap modulo DEPTH.
// Latency: pop data is combinational from the head slot; a push is readable the next cycle.
// Backpressure: none; push while full is accepted only with a simultaneous pop, pop while empty is ignored.
// Ports: clk, rst_n (async active-low), flush_i (sync clear), push_i/push_dat_i, pop_i/pop_dat_o, count_o.
module snake_dir_fifo #(
  parameter  int DEPTH = 63,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [1:0]       push_dat_i,
  input  logic             pop_i,
  output logic [1:0]       pop_dat_o,
  output logic [CNT_W-1:0] count_o
);

  logic [1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Explicit compare-and-wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // When full, a push only fits because the concurrent pop frees the slot it writes.
    push_ok  = push_i && ((count_q != CNT_W'(DEPTH)) || pop_i);
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots behind a nonzero count are ever read.
  always_ff @(posedge clk) begin
    if (!flush_i && push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/snake_tail_tracker.sv
// Tail-side tracker: logs head moves in a direction ring and replays them oldest-first to walk the tail.
// Latency: all outputs registered, effects of a step visible the cycle after the strobe edge.
// Backpressure: none; every step is absorbed, a grow while full is demoted to a plain move.
// Ports: clk, rst_n (async active-low), tif (slave): clear, step, next_dir, grow -> idx_tail,
//        vacate_valid, idx_vacated, length, full.
// Option: define SNAKE_TAIL_GROW_QUEUE_EN to sample grow every cycle into a saturating pending counter.
module snake_tail_tracker
  import snake_pkg::*;
#(
  parameter int         MAX_LEN  = 64,
  parameter logic [5:0] INIT_POS = 6'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  snake_tail_tracker_if.slave  tif
);

  localparam int DEPTH = MAX_LEN - 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [5:0]       tail_q, tail_d;
  logic [5:0]       vac_q, vac_d;
  logic [6:0]       len_q, len_d;
  logic             full_q, full_d;
  logic             vv_q, vv_d;
  logic             grow_req, grow_eff, move, bypass;
  logic             fifo_push, fifo_pop;
  logic [1:0]       pop_dir, move_dir;
  logic [CNT_W-1:0] fifo_cnt;

`ifdef SNAKE_TAIL_GROW_QUEUE_EN
  logic [2:0] pend_q, pend_d;
`endif

  always_comb begin
`ifdef SNAKE_TAIL_GROW_QUEUE_EN
    grow_req = tif.grow || (pend_q != 3'd0);
`else
    grow_req = tif.grow;
`endif
    grow_eff  = tif.step && grow_req && !full_q;
    move      = tif.step && !grow_eff;
    // Length 1: nothing buffered, the tail simply follows this very move.
    bypass    = (fifo_cnt == '0);
    fifo_push = !tif.clear && tif.step && (grow_eff || !bypass);
    fifo_pop  = !tif.clear && move && !bypass;
    move_dir  = bypass ? tif.next_dir : pop_dir;

    tail_d = tail_q;
    vac_d  = vac_q;
    len_d  = len_q;
    vv_d   = 1'b0;
    if (grow_eff) begin
      len_d = len_q + 7'd1;
    end else if (move) begin
      vac_d  = tail_q;
      vv_d   = 1'b1;
      tail_d = step_cell(tail_q, move_dir);
    end
    full_d = (len_d == 7'(MAX_LEN));

    if (tif.clear) begin
      tail_d = INIT_POS;
      vac_d  = 6'd0;
      len_d  = 7'd1;
      vv_d   = 1'b0;
      full_d = 1'b0;
    end
  end

`ifdef SNAKE_TAIL_GROW_QUEUE_EN
  // A pulse that is consumed by the same step nets to zero; a step while full drops its grow entirely.
  always_comb begin
    pend_d = pend_q;
    if (tif.clear) begin
      pend_d = 3'd0;
    end else if (tif.step && grow_req && full_q) begin
      pend_d = pend_q;
    end else if (tif.grow && !grow_eff) begin
      pend_d = (pend_q == 3'd7) ? pend_q : pend_q + 3'd1;
    end else if (!tif.grow && grow_eff) begin
      pend_d = pend_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 3'd0;
    else        pend_q <= pend_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_q <= INIT_POS;
      vac_q  <= 6'd0;
      len_q  <= 7'd1;
      full_q <= 1'b0;
      vv_q   <= 1'b0;
    end else begin
      tail_q <= tail_d;
      vac_q  <= vac_d;
      len_q  <= len_d;
      full_q <= full_d;
      vv_q   <= vv_d;
    end
  end

  snake_dir_fifo #(.DEPTH(DEPTH)) u_dir_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (tif.clear),
    .push_i     (fifo_push),
    .push_dat_i (tif.next_dir),
    .pop_i      (fifo_pop),
    .pop_dat_o  (pop_dir),
    .count_o    (fifo_cnt)
  );

  assign tif.idx_tail     = tail_q;
  assign tif.idx_vacated  = vac_q;
  assign tif.length       = len_q;
  assign tif.full         = full_q;
  assign tif.vacate_valid = vv_q;

endmodule

// File: tb/tb_snake_tail_tracker.sv
// Bench for snake_tail_tracker: two instances (MAX_LEN 4 and 64) driven by identical stimulus.
// The reference keeps the snake body as a queue of occupied cells, tail at the front, head at the back.
module tb_snake_tail_tracker;

  localparam int LEN_S = 4;
  localparam int LEN_L = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_tail_tracker_if if_s ();
  snake_tail_tracker_if if_l ();

  snake_tail_tracker #(.MAX_LEN(LEN_S), .INIT_POS(6'd0)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (if_s)
  );

  snake_tail_tracker #(.MAX_LEN(LEN_L), .INIT_POS(6'd0)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (if_l)
  );

  int checks   = 0;
  int failures = 0;

  logic [5:0] body_s[$];
  logic [5:0] body_l[$];
  int         pend_s, pend_l;
  logic       exp_vv  [2];
  logic [5:0] exp_vac [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Independent torus step from x/y coordinates.
  function automatic logic [5:0] mv(input logic [5:0] c, input logic [1:0] d);
    int x, y;
    x = int'(c) % 8;
    y = int'(c) / 8;
    case (d)
      2'd0:    x = (x + 1) % 8;
      2'd1:    y = (y + 1) % 8;
      2'd2:    x = (x + 7) % 8;
      default: y = (y + 7) % 8;
    endcase
    return 6'(y * 8 + x);
  endfunction

  task automatic model_reset();
    body_s = {};
    body_l = {};
    body_s.push_back(6'd0);
    body_l.push_back(6'd0);
    pend_s = 0;
    pend_l = 0;
    exp_vv[0] = 1'b0;
    exp_vv[1] = 1'b0;
  endtask

  task automatic model_update(input int k, input int maxl, input logic c, input logic s,
                              input logic [1:0] d, input logic g);
    int         len, pend;
    logic       gr;
    logic [5:0] head, vac;
    len  = (k == 0) ? body_s.size() : body_l.size();
    pend = (k == 0) ? pend_s : pend_l;
    exp_vv[k] = 1'b0;
    if (c) begin
      if (k == 0) begin body_s = {}; body_s.push_back(6'd0); end
      else begin body_l = {}; body_l.push_back(6'd0); end
      pend = 0;
    end else begin
`ifdef SNAKE_TAIL_GROW_QUEUE_EN
      gr = g || (pend > 0);
`else
      gr = g;
`endif
      if (s) begin
        head = (k == 0) ? body_s[$] : body_l[$];
        head = mv(head, d);
        if (k == 0) body_s.push_back(head);
        else        body_l.push_back(head);
        if (gr && len < maxl) begin
          if (!g) pend--;
        end else begin
          vac = (k == 0) ? body_s.pop_front() : body_l.pop_front();
          exp_vv[k]  = 1'b1;
          exp_vac[k] = vac;
        end
      end else if (g && pend < 7) begin
        pend++;
      end
    end
    if (k == 0) pend_s = pend;
    else        pend_l = pend;
  endtask

  task automatic check_dut(input int k);
    string      nm;
    logic [5:0] t, v, mt;
    logic [6:0] l;
    logic       f, vv;
    int         maxl, mlen;
    if (k == 0) begin
      nm = "S"; t = if_s.idx_tail; v = if_s.idx_vacated; l = if_s.length; f = if_s.full;
      vv = if_s.vacate_valid; maxl = LEN_S; mlen = body_s.size(); mt = body_s[0];
    end else begin
      nm = "L"; t = if_l.idx_tail; v = if_l.idx_vacated; l = if_l.length; f = if_l.full;
      vv = if_l.vacate_valid; maxl = LEN_L; mlen = body_l.size(); mt = body_l[0];
    end
    check_eq($sformatf("%s.tail", nm), 32'(t), 32'(mt));
    check_eq($sformatf("%s.length", nm), 32'(l), 32'(mlen));
    check_eq($sformatf("%s.full", nm), 32'(f), 32'(mlen == maxl));
    check_eq($sformatf("%s.vacate_valid", nm), 32'(vv), 32'(exp_vv[k]));
    if (exp_vv[k]) check_eq($sformatf("%s.idx_vacated", nm), 32'(v), 32'(exp_vac[k]));
  endtask

  // Entered and left at a falling edge; checks 1 time unit after the rising edge.
  task automatic cycle(input logic c, input logic s, input logic [1:0] d, input logic g);
    if_s.clear = c; if_s.step = s; if_s.next_dir = d; if_s.grow = g;
    if_l.clear = c; if_l.step = s; if_l.next_dir = d; if_l.grow = g;
    @(posedge clk);
    #1;
    model_update(0, LEN_S, c, s, d, g);
    model_update(1, LEN_L, c, s, d, g);
    check_dut(0);
    check_dut(1);
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    check_eq("rst.idx_vacated", 32'(if_l.idx_vacated), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    if_s.clear = 1'b0; if_s.step = 1'b0; if_s.next_dir = 2'd0; if_s.grow = 1'b0;
    if_l.clear = 1'b0; if_l.step = 1'b0; if_l.next_dir = 2'd0; if_l.grow = 1'b0;
    model_reset();
    #12;
    check_dut(0);
    check_dut(1);
    check_eq("rst.idx_vacated", 32'(if_s.idx_vacated), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Grow then move.
    cycle(0, 1, 2'd0, 1);
    check_eq("grow.len", 32'(if_l.length), 32'd2);
    check_eq("grow.tail", 32'(if_l.idx_tail), 32'd0);
    check_eq("grow.vv", 32'(if_l.vacate_valid), 32'd0);
    cycle(0, 1, 2'd0, 0);
    check_eq("move.tail", 32'(if_l.idx_tail), 32'd1);
    check_eq("move.vac", 32'(if_l.idx_vacated), 32'd0);
    check_eq("move.vv", 32'(if_l.vacate_valid), 32'd1);
    cycle(0, 0, 2'd0, 0);
    check_eq("move.vv_drop", 32'(if_l.vacate_valid), 32'd0);

    // Length-1 bypass.
    cycle(1, 0, 2'd0, 0);
    cycle(0, 1, 2'd1, 0);
    check_eq("bypass.tail", 32'(if_l.idx_tail), 32'd8);
    check_eq("bypass.vac", 32'(if_l.idx_vacated), 32'd0);

    // Wrap on both axes through replayed directions.
    cycle(1, 0, 2'd0, 0);
    cycle(0, 1, 2'd2, 1);
    cycle(0, 1, 2'd0, 0);
    check_eq("wrap.x_neg", 32'(if_l.idx_tail), 32'd7);
    cycle(0, 1, 2'd3, 0);
    check_eq("wrap.x_pos", 32'(if_l.idx_tail), 32'd0);
    cycle(0, 1, 2'd0, 0);
    check_eq("wrap.y_neg", 32'(if_l.idx_tail), 32'd56);

    // Fill the small instance; the fourth grow becomes a move.
    cycle(1, 0, 2'd0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 2'd0, 1);
    check_eq("full.len", 32'(if_s.length), 32'd4);
    check_eq("full.flag", 32'(if_s.full), 32'd1);
    cycle(0, 1, 2'd1, 1);
    check_eq("full.len_hold", 32'(if_s.length), 32'd4);
    check_eq("full.vv", 32'(if_s.vacate_valid), 32'd1);
    check_eq("full.tail", 32'(if_s.idx_tail), 32'd1);
    check_eq("full.L_len", 32'(if_l.length), 32'd5);
    for (int i = 0; i < 10; i++)
      cycle(0, 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Clear mid-game at length 5, with a concurrent step.
    cycle(1, 0, 2'd0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 2'($urandom_range(0, 3)), 1);
    check_eq("clr.pre_len", 32'(if_l.length), 32'd5);
    cycle(1, 1, 2'd1, 1);
    check_eq("clr.tail", 32'(if_l.idx_tail), 32'd0);
    check_eq("clr.len", 32'(if_l.length), 32'd1);
    check_eq("clr.vv", 32'(if_l.vacate_valid), 32'd0);

    // Async reset mid-game at length 5.
    for (int i = 0; i < 4; i++) cycle(0, 1, 2'($urandom_range(0, 3)), 1);
    check_eq("arst.pre_len", 32'(if_l.length), 32'd5);
    async_reset();

`ifdef SNAKE_TAIL_GROW_QUEUE_EN
    cycle(1, 0, 2'd0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 2'd0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 2'd0, 0);
      check_eq($sformatf("gq.vv%0d", i), 32'(if_l.vacate_valid), 32'(i == 3));
    end
    check_eq("gq.len", 32'(if_l.length), 32'd4);
`else
    cycle(1, 0, 2'd0, 0);
    cycle(0, 0, 2'd0, 1);
    cycle(0, 1, 2'd0, 0);
    check_eq("nogq.len", 32'(if_l.length), 32'd1);
    check_eq("nogq.vv", 32'(if_l.vacate_valid), 32'd1);
`endif

    // Random mix.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
